// File: rtl/mc_burst_seq_if.sv
// Request/beat handshake bundle for mc_burst_seq.
// master drives requests and acks; slave is the sequencer side.
interface mc_burst_seq_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 4
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              ack;
  logic              abort;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid;
  logic              last;
  logic              busy;
  logic              done;

  modport master (
    output start, start_addr, burst_len, ack, abort,
    input  addr_out, addr_valid, last, busy, done
  );

  modport slave (
    input  start, start_addr, burst_len, ack, abort,
    output addr_out, addr_valid, last, busy, done
  );
endinterface

// File: rtl/mc_burst_seq.sv
// Burst address sequencer: one beat per two cycles, split low/high address increment.
// Define MC_BURST_WRAP_EN to wrap power-of-two bursts within their aligned block.
module mc_burst_seq #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 4
) (
  input logic          clk,
  input logic          rst_n,
  mc_burst_seq_if.slave bus
);

  localparam int unsigned HALF = ADDR_W / 2;

  typedef enum logic [1:0] {StIdle, StIssue, StStep} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [HALF-1:0]   lo_step_q, lo_step_d;
  logic              carry_q, carry_d;
  logic              done_q, done_d;

  logic [HALF-1:0] lo_inc, hi_inc, lo_next, hi_next;
  logic            lo_carry, carry_next;
  logic            accept;

  assign accept = (state_q == StIdle) && bus.start && !bus.abort;
  assign {lo_carry, lo_inc} = {1'b0, addr_q[HALF-1:0]} + {{HALF{1'b0}}, 1'b1};
  assign hi_inc = addr_q[ADDR_W-1:HALF] + {{(HALF-1){1'b0}}, carry_q};

`ifdef MC_BURST_WRAP_EN
  logic [ADDR_W-1:0] mask_q;
  logic [ADDR_W-1:0] start_mask;
  logic              len_pow2;
  logic [HALF-1:0]   m_lo, m_hi;

  // Mask of address bits allowed to step; all ones means linear stepping.
  assign len_pow2   = ((bus.burst_len & (bus.burst_len + LEN_W'(1))) == '0);
  assign start_mask = len_pow2 ? ADDR_W'(bus.burst_len) : {ADDR_W{1'b1}};
  assign m_lo       = mask_q[HALF-1:0];
  assign m_hi       = mask_q[ADDR_W-1:HALF];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (accept) begin
      mask_q <= start_mask;
    end
  end

  // Carry crosses into the high half only when the whole low half is stepping.
  assign lo_next    = (addr_q[HALF-1:0] & ~m_lo) | (lo_inc & m_lo);
  assign carry_next = lo_carry & (&m_lo);
  assign hi_next    = (addr_q[ADDR_W-1:HALF] & ~m_hi) | (hi_inc & m_hi);
`else
  assign lo_next    = lo_inc;
  assign carry_next = lo_carry;
  assign hi_next    = hi_inc;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    lo_step_d = lo_step_q;
    carry_d   = carry_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
          addr_d  = bus.start_addr;
          cnt_d   = bus.burst_len;
          carry_d = 1'b0;
        end
      end
      StIssue: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bus.ack) begin
          if (cnt_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d   = StStep;
            cnt_d     = cnt_q - LEN_W'(1);
            lo_step_d = lo_next;
            carry_d   = carry_next;
          end
        end
      end
      StStep: begin
        // addr_out is only committed here, so an abort keeps the last beat address.
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          state_d = StIssue;
          addr_d  = {hi_next, lo_step_q};
          carry_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      lo_step_q <= '0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      lo_step_q <= lo_step_d;
      carry_q   <= carry_d;
      done_q    <= done_d;
    end
  end

  assign bus.addr_out   = addr_q;
  assign bus.addr_valid = (state_q == StIssue);
  assign bus.last       = (state_q == StIssue) && (cnt_q == '0);
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_mc_burst_seq.sv
// Directed bench for mc_burst_seq; honours MC_BURST_WRAP_EN for the wrap vector.
module tb_mc_burst_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mc_burst_seq_if #(.ADDR_W(24), .LEN_W(4)) bus_if ();

  mc_burst_seq #(.ADDR_W(24), .LEN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, " addr_out"}, 32'(bus_if.addr_out), 32'h0);
    check_eq({tag, " addr_valid"}, 32'(bus_if.addr_valid), 32'h0);
    check_eq({tag, " last"}, 32'(bus_if.last), 32'h0);
    check_eq({tag, " busy"}, 32'(bus_if.busy), 32'h0);
    check_eq({tag, " done"}, 32'(bus_if.done), 32'h0);
  endtask

  // Burst with ack held high; exp[i] is the hand-computed address of beat i.
  task automatic run_burst(input string tag, input logic [23:0] a, input logic [3:0] len,
                           input logic [3:0][23:0] exp);
    @(negedge clk);
    bus_if.start      = 1'b1;
    bus_if.start_addr = a;
    bus_if.burst_len  = len;
    bus_if.ack        = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      check_eq($sformatf("%s beat%0d valid", tag, i), 32'(bus_if.addr_valid), 32'h1);
      check_eq($sformatf("%s beat%0d addr", tag, i), 32'(bus_if.addr_out), 32'(exp[i]));
      check_eq($sformatf("%s beat%0d last", tag, i), 32'(bus_if.last), 32'(i == int'(len)));
      @(negedge clk);
      if (i < int'(len)) begin
        check_eq($sformatf("%s step%0d valid", tag, i), 32'(bus_if.addr_valid), 32'h0);
        check_eq($sformatf("%s step%0d busy", tag, i), 32'(bus_if.busy), 32'h1);
        @(negedge clk);
      end
    end
    check_eq({tag, " done"}, 32'(bus_if.done), 32'h1);
    check_eq({tag, " idle busy"}, 32'(bus_if.busy), 32'h0);
    check_eq({tag, " retained addr"}, 32'(bus_if.addr_out), 32'(exp[len]));
    bus_if.ack = 1'b0;
    @(negedge clk);
    check_eq({tag, " done pulse"}, 32'(bus_if.done), 32'h0);
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    rst_n             = 1'b0;
    bus_if.start      = 1'b0;
    bus_if.start_addr = '0;
    bus_if.burst_len  = '0;
    bus_if.ack        = 1'b0;
    bus_if.abort      = 1'b0;
    #3;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_burst("lin4", 24'h000010, 4'd3, {24'h000013, 24'h000012, 24'h000011, 24'h000010});
    run_burst("carry", 24'h000FFF, 4'd1, {24'h0, 24'h0, 24'h001000, 24'h000FFF});
    run_burst("wrapall", 24'hFFFFFF, 4'd1, {24'h0, 24'h0, 24'h000000, 24'hFFFFFF});
`ifdef MC_BURST_WRAP_EN
    run_burst("wrap4", 24'h00000E, 4'd3, {24'h00000D, 24'h00000C, 24'h00000F, 24'h00000E});
`else
    run_burst("wrap4", 24'h00000E, 4'd3, {24'h000011, 24'h000010, 24'h00000F, 24'h00000E});
`endif
    run_burst("lin3", 24'h00000E, 4'd2, {24'h0, 24'h000010, 24'h00000F, 24'h00000E});

    // Stall without ack; start while busy must be ignored.
    @(negedge clk);
    bus_if.start      = 1'b1;
    bus_if.start_addr = 24'h000040;
    bus_if.burst_len  = 4'd1;
    @(negedge clk);
    bus_if.start_addr = 24'h000099;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("stall%0d valid", i), 32'(bus_if.addr_valid), 32'h1);
      check_eq($sformatf("stall%0d addr", i), 32'(bus_if.addr_out), 32'h40);
      check_eq($sformatf("stall%0d last", i), 32'(bus_if.last), 32'h0);
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    bus_if.ack   = 1'b1;
    @(negedge clk);
    check_eq("stall step valid", 32'(bus_if.addr_valid), 32'h0);
    @(negedge clk);
    check_eq("stall beat1 addr", 32'(bus_if.addr_out), 32'h41);
    check_eq("stall beat1 last", 32'(bus_if.last), 32'h1);
    @(negedge clk);
    check_eq("stall done", 32'(bus_if.done), 32'h1);
    bus_if.ack = 1'b0;
    @(negedge clk);

    // Abort in IDLE blocks a simultaneous start.
    bus_if.abort      = 1'b1;
    bus_if.start      = 1'b1;
    bus_if.start_addr = 24'h000077;
    @(negedge clk);
    check_eq("idle abort busy", 32'(bus_if.busy), 32'h0);
    check_eq("idle abort valid", 32'(bus_if.addr_valid), 32'h0);
    bus_if.abort = 1'b0;
    bus_if.start = 1'b0;

    // Abort with ack on beat 3 of an 8-beat burst.
    @(negedge clk);
    bus_if.start      = 1'b1;
    bus_if.start_addr = 24'h000100;
    bus_if.burst_len  = 4'd7;
    bus_if.ack        = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("abort beat%0d addr", i), 32'(bus_if.addr_out), 32'(24'h100 + i));
      @(negedge clk);
      @(negedge clk);
    end
    check_eq("abort beat3 addr", 32'(bus_if.addr_out), 32'h103);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    bus_if.ack   = 1'b0;
    check_eq("abort valid", 32'(bus_if.addr_valid), 32'h0);
    check_eq("abort busy", 32'(bus_if.busy), 32'h0);
    check_eq("abort done", 32'(bus_if.done), 32'h0);
    check_eq("abort retained addr", 32'(bus_if.addr_out), 32'h103);
    @(negedge clk);
    check_eq("abort no late done", 32'(bus_if.done), 32'h0);

    // Reset asserted during STEP of a 4-beat burst.
    bus_if.start      = 1'b1;
    bus_if.start_addr = 24'h000030;
    bus_if.burst_len  = 4'd3;
    bus_if.ack        = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    check_eq("pre-reset step busy", 32'(bus_if.busy), 32'h1);
    check_eq("pre-reset step valid", 32'(bus_if.addr_valid), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("midreset");
    @(negedge clk);
    rst_n      = 1'b1;
    bus_if.ack = 1'b0;
    @(negedge clk);
    check_idle_zero("post-reset");
    run_burst("single", 24'h000020, 4'd0, {24'h0, 24'h0, 24'h0, 24'h000020});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
